// File: rtl/issue2_sched_pkg.sv
// Shared types for the dual-issue pairing scheduler: FSM states, queue entry
// layout and the uncompressed-instruction encoding.
package issue2_sched_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    BLOCK = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } iq_entry_t;

  localparam logic [1:0] INSTR_UNCOMPRESSED = 2'b11;

endpackage

// File: rtl/issue2_instr_queue.sv
// Circular instruction buffer with single push, pop of one or two entries and
// flush. Exposes the head entry and the one behind it for pair formation.
module issue2_instr_queue
  import issue2_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_addr,
  input  logic                     pop1,
  input  logic                     pop2,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              e0_instr,
  output logic [31:0]              e0_addr,
  output logic [31:0]              e1_instr,
  output logic [31:0]              e1_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] pop_n;
  iq_entry_t        head;
  iq_entry_t        next;

  always_comb begin
    pop_n = '0;
    if (pop2)      pop_n = CNT_W'(2);
    else if (pop1) pop_n = CNT_W'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
      count  <= count + CNT_W'(push) - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: push_instr, addr: push_addr};
  end

  assign head     = mem[rd_ptr];
  assign next     = mem[rd_ptr + PTR_W'(1)];
  assign e0_instr = head.instr;
  assign e0_addr  = head.addr;
  assign e1_instr = next.instr;
  assign e1_addr  = next.addr;

endmodule

// File: rtl/issue2_pair_scheduler.sv
// Prefetch-stage dual-issue scheduler: buffers fetched instructions, offers the
// head pair to the external allocator and issues one or two per ID handshake.
module issue2_pair_scheduler
  import issue2_sched_pkg::*;
#(
  parameter int DEPTH              = 4,
  parameter int FLUSH_BLOCK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_instr_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic        di_en_i,
  output logic [31:0] alloc_pi_instr_o,
  output logic [31:0] alloc_i2_instr_o,
  output logic        alloc_in_line_ok_o,
  output logic        alloc_unusual_o,
  input  logic        alloc_ok_i,
  output logic        pi_valid_o,
  output logic [31:0] pi_instr_o,
  output logic [31:0] pi_addr_o,
  output logic        i2_valid_o,
  output logic [31:0] i2_instr_o,
  input  logic        id_ready_i,
  output logic [31:0] pair_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BLK_W = $clog2(FLUSH_BLOCK_CYCLES + 1);
  localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(FLUSH_BLOCK_CYCLES);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [CNT_W-1:0] count;
  logic [31:0]      e0_instr, e0_addr, e1_instr, e1_addr;
  logic             push, hs, pop1, pop2;
  sched_state_e     state, state_nxt;
  logic [BLK_W-1:0] blk_cnt, blk_cnt_nxt;

  issue2_instr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_instr (fetch_instr_i),
    .push_addr  (fetch_addr_i),
    .pop1       (pop1),
    .pop2       (pop2),
    .flush      (flush_i),
    .count      (count),
    .e0_instr   (e0_instr),
    .e0_addr    (e0_addr),
    .e1_instr   (e1_instr),
    .e1_addr    (e1_addr)
  );

  // Readiness ignores same-cycle pops so there is no ready-from-ready path.
  assign fetch_ready_o = (count < CNT_W'(DEPTH)) && !flush_i;
  assign push          = fetch_valid_i && fetch_ready_o;

  assign alloc_pi_instr_o   = e0_instr;
  assign alloc_i2_instr_o   = e1_instr;
  assign alloc_in_line_ok_o = (count >= CNT_W'(2))
                              && (e0_instr[1:0] == INSTR_UNCOMPRESSED)
                              && (e1_instr[1:0] == INSTR_UNCOMPRESSED)
                              && (e1_addr == e0_addr + 32'd4);
  assign alloc_unusual_o    = (state == BLOCK);

  assign pi_valid_o = (count >= CNT_W'(1)) && !flush_i;
  assign pi_instr_o = e0_instr;
  assign pi_addr_o  = e0_addr;
  assign i2_valid_o = pi_valid_o && (count >= CNT_W'(2)) && alloc_ok_i;
  assign i2_instr_o = e1_instr;

  assign hs   = id_ready_i && pi_valid_o;
  assign pop2 = hs && i2_valid_o;
  assign pop1 = hs && !i2_valid_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BLOCK;
      blk_cnt <= BLK_INIT;
    end else begin
      state   <= state_nxt;
      blk_cnt <= blk_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    blk_cnt_nxt = blk_cnt;
    if (flush_i) begin
      state_nxt   = BLOCK;
      blk_cnt_nxt = BLK_INIT;
    end else if (state == BLOCK) begin
      blk_cnt_nxt = blk_cnt - BLK_W'(1);
      if (blk_cnt <= BLK_W'(1)) state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       pair_cnt_o <= '0;
    else if (pop2) pair_cnt_o <= sat_inc(pair_cnt_o);
  end

endmodule

// File: tb/tb_issue2_pair_scheduler.sv
// Bench for issue2_pair_scheduler: directed vector table, a flush-reload
// sequence and a randomized run against a reference queue model.
module tb_issue2_pair_scheduler;
  import issue2_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic [31:0] fetch_instr_i, fetch_addr_i;
  logic        fetch_ready_o;
  logic        flush_i, di_en_i;
  logic [31:0] alloc_pi_instr_o, alloc_i2_instr_o;
  logic        alloc_in_line_ok_o, alloc_unusual_o, alloc_ok_i;
  logic        pi_valid_o;
  logic [31:0] pi_instr_o, pi_addr_o;
  logic        i2_valid_o;
  logic [31:0] i2_instr_o;
  logic        id_ready_i;
  logic [31:0] pair_cnt_o;
  logic        verdict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Allocator stand-in: refuses during the block-out window or when disabled.
  always_comb alloc_ok_i = di_en_i & alloc_in_line_ok_o & ~alloc_unusual_o & verdict;

  issue2_pair_scheduler #(.DEPTH(4), .FLUSH_BLOCK_CYCLES(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_instr_i      (fetch_instr_i),
    .fetch_addr_i       (fetch_addr_i),
    .fetch_ready_o      (fetch_ready_o),
    .flush_i            (flush_i),
    .di_en_i            (di_en_i),
    .alloc_pi_instr_o   (alloc_pi_instr_o),
    .alloc_i2_instr_o   (alloc_i2_instr_o),
    .alloc_in_line_ok_o (alloc_in_line_ok_o),
    .alloc_unusual_o    (alloc_unusual_o),
    .alloc_ok_i         (alloc_ok_i),
    .pi_valid_o         (pi_valid_o),
    .pi_instr_o         (pi_instr_o),
    .pi_addr_o          (pi_addr_o),
    .i2_valid_o         (i2_valid_o),
    .i2_instr_o         (i2_instr_o),
    .id_ready_i         (id_ready_i),
    .pair_cnt_o         (pair_cnt_o)
  );

  typedef struct {
    logic        fv;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fl, rdy, di;
    logic        frdy, piv;
    logic [31:0] pi_i, pi_a;
    logic        i2v;
    logic [31:0] i2_i;
    logic        unus, inl;
    logic [31:0] pair;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fv, logic [31:0] instr, logic [31:0] addr,
                              logic fl, logic rdy, logic di, logic frdy, logic piv,
                              logic [31:0] pi_i, logic [31:0] pi_a, logic i2v,
                              logic [31:0] i2_i, logic unus, logic inl, logic [31:0] pair);
    vec_t v;
    v.fv = fv; v.instr = instr; v.addr = addr; v.fl = fl; v.rdy = rdy; v.di = di;
    v.frdy = frdy; v.piv = piv; v.pi_i = pi_i; v.pi_a = pi_a; v.i2v = i2v;
    v.i2_i = i2_i; v.unus = unus; v.inl = inl; v.pair = pair;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] instr, input logic [31:0] addr,
                       input logic fl, input logic rdy, input logic di);
    fetch_valid_i = fv;
    fetch_instr_i = instr;
    fetch_addr_i  = addr;
    flush_i       = fl;
    id_ready_i    = rdy;
    di_en_i       = di;
  endtask

  iq_entry_t   mq[$];
  logic        m_block;
  int          m_blk;
  logic [31:0] m_pair;
  logic [31:0] next_addr;

  initial begin
    //      fv instr         addr         fl rdy di  frdy piv pi_i          pi_a         i2v i2_i          unus inl pair
    vecs.push_back(mk(1, 32'h00000013, 32'h100, 0, 0, 1,  1, 0, 32'h0,        32'h0,   0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 32'h00000033, 32'h104, 0, 1, 1,  1, 1, 32'h00000013, 32'h100, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 32'h00000093, 32'h108, 0, 0, 1,  1, 1, 32'h00000033, 32'h104, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 1, 1,  1, 1, 32'h00000033, 32'h104, 1, 32'h00000093, 0, 1, 0));
    vecs.push_back(mk(1, 32'h00100093, 32'h200, 0, 0, 1,  1, 0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 32'h00200113, 32'h208, 0, 0, 1,  1, 1, 32'h00100093, 32'h200, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 1, 1,  1, 1, 32'h00100093, 32'h200, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 1, 1,  1, 1, 32'h00200113, 32'h208, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 32'h00004501, 32'h300, 0, 0, 1,  1, 0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 32'h00000013, 32'h302, 0, 0, 1,  1, 1, 32'h00004501, 32'h300, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 1, 1,  1, 1, 32'h00004501, 32'h300, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 1, 1,  1, 1, 32'h00000013, 32'h302, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 32'h00000013, 32'h400, 0, 0, 1,  1, 0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 32'h00000033, 32'h404, 0, 0, 1,  1, 1, 32'h00000013, 32'h400, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 32'h00000093, 32'h408, 0, 0, 1,  1, 1, 32'h00000013, 32'h400, 1, 32'h00000033, 0, 1, 1));
    vecs.push_back(mk(1, 32'h000000B3, 32'h40C, 0, 0, 1,  1, 1, 32'h00000013, 32'h400, 1, 32'h00000033, 0, 1, 1));
    vecs.push_back(mk(1, 32'h00000073, 32'h500, 0, 0, 1,  0, 1, 32'h00000013, 32'h400, 1, 32'h00000033, 0, 1, 1));
    vecs.push_back(mk(1, 32'h00000073, 32'h500, 0, 1, 1,  0, 1, 32'h00000013, 32'h400, 1, 32'h00000033, 0, 1, 1));
    vecs.push_back(mk(1, 32'h00000013, 32'h600, 0, 0, 1,  1, 1, 32'h00000093, 32'h408, 1, 32'h000000B3, 0, 1, 2));
    vecs.push_back(mk(1, 32'h00000033, 32'h700, 1, 1, 1,  0, 0, 32'h0,        32'h0,   0, 32'h0,        0, 1, 2));
    vecs.push_back(mk(1, 32'h00000013, 32'h800, 0, 0, 1,  1, 0, 32'h0,        32'h0,   0, 32'h0,        1, 0, 2));
    vecs.push_back(mk(1, 32'h00000033, 32'h804, 0, 0, 1,  1, 1, 32'h00000013, 32'h800, 0, 32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 1, 0,  1, 1, 32'h00000013, 32'h800, 0, 32'h0,        0, 1, 2));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 1, 1,  1, 1, 32'h00000033, 32'h804, 0, 32'h0,        0, 0, 2));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 0, 1,  1, 0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 2));

    rst = 1'b1;
    verdict = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk1("reset.pi_valid", pi_valid_o, 1'b0);
    chk1("reset.i2_valid", i2_valid_o, 1'b0);
    chk1("reset.unusual", alloc_unusual_o, 1'b1);
    chk32("reset.pair_cnt", pair_cnt_o, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].fv, vecs[i].instr, vecs[i].addr, vecs[i].fl, vecs[i].rdy, vecs[i].di);
      #3;
      chk1($sformatf("v%0d.fetch_ready", i), fetch_ready_o, vecs[i].frdy);
      chk1($sformatf("v%0d.pi_valid", i), pi_valid_o, vecs[i].piv);
      if (vecs[i].piv) begin
        chk32($sformatf("v%0d.pi_instr", i), pi_instr_o, vecs[i].pi_i);
        chk32($sformatf("v%0d.pi_addr", i), pi_addr_o, vecs[i].pi_a);
      end
      chk1($sformatf("v%0d.i2_valid", i), i2_valid_o, vecs[i].i2v);
      if (vecs[i].i2v) chk32($sformatf("v%0d.i2_instr", i), i2_instr_o, vecs[i].i2_i);
      chk1($sformatf("v%0d.unusual", i), alloc_unusual_o, vecs[i].unus);
      chk1($sformatf("v%0d.in_line_ok", i), alloc_in_line_ok_o, vecs[i].inl);
      chk32($sformatf("v%0d.pair_cnt", i), pair_cnt_o, vecs[i].pair);
      @(posedge clk);
      #1;
    end

    // Back-to-back flushes must restart the block-out window.
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    #3 chk1("reload.unusual0", alloc_unusual_o, 1'b0);
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    #3 chk1("reload.unusual1", alloc_unusual_o, 1'b1);
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    #3 chk1("reload.unusual2", alloc_unusual_o, 1'b1);
    @(posedge clk); #1;
    #3 chk1("reload.unusual3", alloc_unusual_o, 1'b1);
    @(posedge clk); #1;
    #3 chk1("reload.unusual4", alloc_unusual_o, 1'b0);
    chk32("reload.pair_cnt", pair_cnt_o, 32'h2);
    @(posedge clk); #1;

    // Randomized run against a reference queue model.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    m_block = 1'b1;
    m_blk = 2;
    m_pair = 32'h0;
    next_addr = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      logic        fv, fl, rdy, di, cmp, exp_frdy, exp_piv, exp_i2, exp_inl;
      logic [31:0] tmp, instr, addr;
      fv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      di  = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 31) == 0);
      cmp = ($urandom_range(0, 5) == 0);
      verdict = ($urandom_range(0, 3) != 0);
      tmp = $urandom();
      instr = {tmp[31:2], cmp ? 2'b01 : 2'b11};
      if ($urandom_range(0, 3) == 0) begin
        tmp = $urandom();
        addr = {tmp[31:2], 2'b00};
      end else begin
        addr = next_addr;
      end
      drive(fv, instr, addr, fl, rdy, di);
      #3;
      exp_frdy = (mq.size() < 4) && !fl;
      exp_piv  = (mq.size() >= 1) && !fl;
      exp_i2   = exp_piv && (mq.size() >= 2) && alloc_ok_i;
      exp_inl  = 1'b0;
      if (mq.size() >= 2)
        exp_inl = (mq[0].instr[1:0] == 2'b11) && (mq[1].instr[1:0] == 2'b11)
                  && (mq[1].addr == mq[0].addr + 32'd4);
      chk1("rnd.fetch_ready", fetch_ready_o, exp_frdy);
      chk1("rnd.pi_valid", pi_valid_o, exp_piv);
      if (exp_piv) begin
        chk32("rnd.pi_instr", pi_instr_o, mq[0].instr);
        chk32("rnd.pi_addr", pi_addr_o, mq[0].addr);
      end
      chk1("rnd.i2_valid", i2_valid_o, exp_i2);
      if (exp_i2) chk32("rnd.i2_instr", i2_instr_o, mq[1].instr);
      chk1("rnd.i2_in_block", i2_valid_o && m_block, 1'b0);
      chk1("rnd.unusual", alloc_unusual_o, m_block);
      chk1("rnd.in_line_ok", alloc_in_line_ok_o, exp_inl);
      chk32("rnd.pair_cnt", pair_cnt_o, m_pair);

      if (fl) begin
        mq.delete();
        m_block = 1'b1;
        m_blk = 2;
      end else begin
        if (rdy && exp_piv) begin
          void'(mq.pop_front());
          if (exp_i2) begin
            void'(mq.pop_front());
            m_pair = m_pair + 32'd1;
          end
        end
        if (fv && exp_frdy) begin
          mq.push_back('{instr: instr, addr: addr});
          next_addr = addr + (cmp ? 32'd2 : 32'd4);
        end
        if (m_block) begin
          if (m_blk <= 1) m_block = 1'b0;
          m_blk = m_blk - 1;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue2_pair_scheduler.md
# issue2_pair_scheduler

Dual-issue pairing scheduler in the prefetch stage. It buffers fetched instructions and presents the head pair (primary plus issue-2 candidate) to a combinational `issue2_allocator`. It then issues one instruction, or both, to the ID stage per handshake, based on the allocator verdict. It also owns the dual-issue block-out window after pipeline flushes and counts issued pairs.

## Interface
Parameters:
- `DEPTH`, 4: instruction queue entries; power of two, ≥2.
- `FLUSH_BLOCK_CYCLES`, 2: cycles dual issue stays disabled after a flush; ≥1.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `fetch_valid_i` in 1, `fetch_instr_i` in 32, `fetch_addr_i` in 32: fetch push channel.
- `fetch_ready_o` out 1: queue can accept a push this cycle.
- `flush_i` in 1: branch/exception redirect; discards queue contents.
- `di_en_i` in 1: global dual-issue enable; forwarded to allocator.
- `alloc_pi_instr_o` out 32, `alloc_i2_instr_o` out 32: head / head+1 instructions to allocator.
- `alloc_in_line_ok_o` out 1: head+1 is sequential to head and both are uncompressed.
- `alloc_unusual_o` out 1: drives allocator `pi_unusal_state_prevent_di`.
- `alloc_ok_i` in 1: allocator `i2_instr_allocate_ok`.
- `pi_valid_o` out 1, `pi_instr_o` out 32, `pi_addr_o` out 32: primary issue to ID.
- `i2_valid_o` out 1, `i2_instr_o` out 32: second issue to ID.
- `id_ready_i` in 1: ID accepts the offered instruction(s).
- `pair_cnt_o` out 32: saturating count of issued pairs.

## Operation
- The queue is a circular buffer. Each entry holds {instr, addr}. It tracks `rd_ptr`, `wr_ptr` and `count` (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Push occurs when `fetch_valid_i && fetch_ready_o`, where `fetch_ready_o = (count < DEPTH) && !flush_i`. Readiness is independent of same-cycle pop.
- `alloc_in_line_ok_o` = `count≥2 && e0.instr[1:0]==2'b11 && e1.instr[1:0]==2'b11 && e1.addr == e0.addr+4` (32-bit wraparound add).
- FSM states (package enum):
  - RUN: normal operation.
  - BLOCK: dual issue suppressed.
- Transitions:
  - Reset → BLOCK with `blk_cnt=FLUSH_BLOCK_CYCLES`.
  - `flush_i` in any state → BLOCK with `blk_cnt=FLUSH_BLOCK_CYCLES`.
  - In BLOCK, `blk_cnt` decrements each cycle. At 1 it moves to RUN.
- `alloc_unusual_o` = (state==BLOCK).
- `pi_valid_o` = `count≥1 && !flush_i`.
- `i2_valid_o` = `pi_valid_o && count≥2 && alloc_ok_i`.
- On a handshake (`id_ready_i && pi_valid_o`), the queue pops 2 if `i2_valid_o`, else 1. `pair_cnt_o` increments when 2 are popped and saturates at 0xFFFF_FFFF.
- Simultaneous push and pop: `count` += push − pop. A push into a full queue that also pops is still refused, because `fetch_ready_o` was low.
- Flush has priority over push and pop. `count`, `rd_ptr` and `wr_ptr` go to 0, and the push is dropped. `pair_cnt_o` is not cleared.
- With `di_en_i=0`, the allocator returns 0, so issue is single only; the FSM still runs.

## Timing
- Reset values:
  - `count=0`, pointers 0, state BLOCK, `blk_cnt=FLUSH_BLOCK_CYCLES`, `pair_cnt_o=0`.
  - Hence `pi_valid_o=0`, `i2_valid_o=0`, `alloc_unusual_o=1`, `fetch_ready_o=1` (after reset deasserts).
- Latency: an instruction pushed in cycle N is offered on `pi_valid_o` in cycle N+1 at the earliest; there is no bypass.
- `pi_*` and `alloc_*` outputs are driven directly from registered queue state.
- `i2_valid_o` combinationally depends on `alloc_ok_i`, which makes one combinational loop-free path through the allocator.
- Once `pi_valid_o` is asserted, `pi_instr_o` is stable until the handshake or a flush.
- `i2_valid_o` may deassert without a handshake if the pair changes (a flush), or stay low if the allocator verdict is 0.
- After a flush, the first pair may dual-issue no earlier than `FLUSH_BLOCK_CYCLES` cycles after the flush cycle.

## Structure
- Package `issue2_sched_pkg`: `sched_state_e` {RUN, BLOCK}, `iq_entry_t` struct {instr[31:0], addr[31:0]}, `INSTR_UNCOMPRESSED=2'b11`.
- Sub-module `issue2_instr_queue`: circular buffer with push, pop1/pop2 and flush, exposing entries 0 and 1 and `count`.
- Top level: FSM, in-line check, issue logic and counter. The top level does not instantiate `issue2_allocator`; it connects to it through ports.

## Test plan
- Reset, push 0x00000013@0x100 and 0x00000033@0x104, hold `alloc_ok_i=1` → `alloc_unusual_o=1` for 2 cycles and single issue only during that window; in RUN, a remaining pair dual-issues and `pair_cnt_o=1`.
- In RUN, push @0x200 and @0x208 (non-sequential) → `alloc_in_line_ok_o=0`; with the allocator model producing 0, two single issues occur.
- Push a compressed 0x4501@0x300 followed by @0x302 → `alloc_in_line_ok_o=0`.
- Fill 4 entries with `id_ready_i=0` → `fetch_ready_o=0`; a push offered while full is not accepted; raise `id_ready_i` with a pair OK → `count` goes 4→2 and `fetch_ready_o=1` next cycle.
- Assert `flush_i` with 3 entries plus a concurrent push → `count=0` next cycle, `pi_valid_o=0`, state BLOCK, `pair_cnt_o` unchanged.
- Random push/ID-backpressure/verdict for 10k cycles against a reference queue model → order preserved, no loss or duplication, `i2_valid_o` never asserted while in BLOCK.
